// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: decodes an instruction, holds it through a fixed
// multiply/divide or load latency, then issues registered control signals.
module control_unit_mc #(
    parameter int MULDIV_LAT = 4,
    parameter int MEM_LAT    = 2,
    parameter bit HAS_DIV    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic       flush,
    input  logic [1:0] instruction_type,
    input  logic [4:0] func,
    output logic       ctrl_valid,
    output logic       illegal,
    output logic       BranchB,
    output logic       BranchI,
    output logic       BranchGEQ,
    output logic       BranchLEQ,
    output logic       MemToReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic       RegSrc2,
    output logic       RegSrc1,
    output logic [2:0] ALUOp,
    output logic [1:0] ImmSrc
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] MEMW  = 2'd2;
    localparam logic [1:0] ISSUE = 2'd3;

    // Bits kept while waiting: ALUOp/ALUSrc/ImmSrc/RegSrc*/MemRead/MemToReg.
    localparam logic [15:0] HOLD_MASK = 16'h0D7F;

    logic [1:0]  state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [15:0] dec, dec_q, dec_n, ctl_q, ctl_n;
    logic        cv_n, illegal_n, accept;

    logic       d_legal, d_muldiv, d_div, d_load;
    logic [2:0] d_aluop;
    logic [1:0] d_immsrc;
    logic       d_alusrc, d_regwrite, d_regsrc;
    logic       d_memread, d_memtoreg, d_memwrite;
    logic       d_bb, d_bi, d_bgeq, d_bleq;

    always_comb begin
        d_legal    = 1'b0;
        d_muldiv   = 1'b0;
        d_div      = 1'b0;
        d_load     = 1'b0;
        d_aluop    = 3'b000;
        d_immsrc   = 2'b00;
        d_alusrc   = 1'b0;
        d_regwrite = 1'b0;
        d_regsrc   = 1'b0;
        d_memread  = 1'b0;
        d_memtoreg = 1'b0;
        d_memwrite = 1'b0;
        d_bb       = 1'b0;
        d_bi       = 1'b0;
        d_bgeq     = 1'b0;
        d_bleq     = 1'b0;
        case (instruction_type)
            2'b01: begin
                d_legal    = 1'b1;
                d_regwrite = 1'b1;
                d_alusrc   = func[4];
                d_immsrc   = func[4] ? 2'b10 : 2'b00;
                case (func)
                    5'b00000, 5'b10100: d_aluop = 3'b000;
                    5'b00001, 5'b10101: d_aluop = 3'b001;
                    5'b00010, 5'b10110: begin
                        d_aluop  = 3'b010;
                        d_muldiv = 1'b1;
                    end
                    5'b00011, 5'b10111: begin
                        d_aluop  = 3'b011;
                        d_muldiv = 1'b1;
                        d_div    = 1'b1;
                    end
                    5'b11000: d_aluop = 3'b100;
                    5'b11001: d_aluop = 3'b101;
                    5'b01011, 5'b11010, 5'b11100: d_aluop = 3'b110;
                    default:  d_legal = 1'b0;
                endcase
                if (d_div && !HAS_DIV) d_legal = 1'b0;
            end
            2'b10: begin
                d_legal  = 1'b1;
                d_aluop  = 3'b001;
                d_regsrc = 1'b1;
                case (func[4:3])
                    2'b00: d_bb   = 1'b1;
                    2'b01: d_bleq = 1'b1;
                    2'b10: d_bi   = 1'b1;
                    2'b11: d_bgeq = 1'b1;
                endcase
            end
            2'b00: begin
                d_alusrc = 1'b1;
                d_immsrc = 2'b01;
                case (func[4:3])
                    2'b00: begin
                        d_legal    = 1'b1;
                        d_load     = 1'b1;
                        d_memread  = 1'b1;
                        d_memtoreg = 1'b1;
                        d_regwrite = 1'b1;
                    end
                    2'b01: begin
                        d_legal    = 1'b1;
                        d_memwrite = 1'b1;
                    end
                    default: d_legal = 1'b0;
                endcase
            end
            default: d_legal = 1'b0;
        endcase
        // Illegal codes drive every field to zero.
        dec = d_legal ? {d_bb, d_bi, d_bgeq, d_bleq, d_memtoreg, d_memread, d_memwrite,
                         d_alusrc, d_regwrite, d_regsrc, d_regsrc, d_aluop, d_immsrc} : '0;
    end

    assign instr_ready = ((state == IDLE) || (state == ISSUE)) && !flush;
    assign accept      = instr_valid && instr_ready;
    assign dec_n       = accept ? dec : dec_q;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        illegal_n = 1'b0;
        if (flush) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
        end else begin
            case (state)
                IDLE, ISSUE: begin
                    state_n = IDLE;
                    if (accept) begin
                        if (!d_legal) begin
                            illegal_n = 1'b1;
                        end else if (d_muldiv && (MULDIV_LAT > 1)) begin
                            state_n = EXEC;
                            cnt_n   = 4'(MULDIV_LAT - 1);
                        end else if (d_load && (MEM_LAT > 1)) begin
                            state_n = MEMW;
                            cnt_n   = 4'(MEM_LAT - 1);
                        end else begin
                            state_n = ISSUE;
                        end
                    end
                end
                default: begin
                    if (cnt <= 4'd1) begin
                        state_n = ISSUE;
                        cnt_n   = 4'd0;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    // Outputs are a function of the state being entered, so they line up with it.
    always_comb begin
        ctl_n = '0;
        cv_n  = 1'b0;
        case (state_n)
            ISSUE: begin
                ctl_n = dec_n;
                cv_n  = 1'b1;
            end
            EXEC, MEMW: ctl_n = dec_n & HOLD_MASK;
            default: ctl_n = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            ctl_q      <= '0;
            ctrl_valid <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ctl_q      <= ctl_n;
            ctrl_valid <= cv_n;
            illegal    <= illegal_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) dec_q <= dec;
    end

    assign {BranchB, BranchI, BranchGEQ, BranchLEQ, MemToReg, MemRead, MemWrite,
            ALUSrc, RegWrite, RegSrc2, RegSrc1, ALUOp, ImmSrc} = ctl_q;

endmodule
